// File: rtl/ariele_rr_arbiter.sv
// rtl/ariele_rr_arbiter.sv - round-robin N-master to one-slave arbiter with in-order read ID FIFO

module ariele_rr_id_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_tvalid,
  input  logic [DW-1:0]          wr_tdata,
  input  logic                   rd_tready,
  output logic [DW-1:0]          rd_tdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_tvalid) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_tready) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_tvalid && !rd_tready)
        count <= count + CNT_W'(1);
      else if (!wr_tvalid && rd_tready)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_tvalid) mem[wr_ptr] <= wr_tdata;
  end

  assign rd_tdata = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
endmodule

module ariele_rr_arbiter #(
  parameter int NUM_M     = 4,
  parameter int ID_W      = $clog2(NUM_M),
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_M-1:0]           m_req_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M*32-1:0]        m_addr_bi,
  input  logic [NUM_M*4-1:0]         m_be_i,
  input  logic [NUM_M*32-1:0]        m_wdata_bi,
  output logic [NUM_M-1:0]           m_ack_o,
  output logic [NUM_M-1:0]           m_resp_o,
  output logic [NUM_M*32-1:0]        m_rdata_bo,
  output logic                       s_req_o,
  output logic                       s_we_o,
  output logic [31:0]                s_addr_bo,
  output logic [3:0]                 s_be_o,
  output logic [31:0]                s_wdata_bo,
  input  logic                       s_ack_i,
  input  logic                       s_resp_i,
  input  logic [31:0]                s_rdata_bi,
  output logic [$clog2(MAX_OUTST):0] outst_o,
  output logic                       err_o
);
  logic [ID_W-1:0] rr_ptr;
  logic            lock;
  logic [ID_W-1:0] lock_id;
  logic            err_q;

  logic [ID_W-1:0] cand;
  logic            cand_vld;
  logic [ID_W-1:0] idx;
  logic            blocked;
  logic            accept;
  logic            withdrew;

  logic                       fifo_push;
  logic                       fifo_pop;
  logic [ID_W-1:0]            fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(MAX_OUTST):0] fifo_count;

  // Locked grant sticks to lock_id; otherwise scan upward from rr_ptr with wrap.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    idx      = '0;
    if (lock) begin
      cand     = lock_id;
      cand_vld = m_req_i[lock_id];
    end else begin
      for (int k = 0; k < NUM_M; k++) begin
        idx = ID_W'((int'(rr_ptr) + k) % NUM_M);
        if (!cand_vld && m_req_i[idx]) begin
          cand_vld = 1'b1;
          cand     = idx;
        end
      end
    end
  end

  assign withdrew = lock && !m_req_i[lock_id];

  // A full FIFO stalls a read candidate without letting a later write overtake it.
  assign blocked  = cand_vld && !m_we_i[cand] && fifo_full;

  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_o     = '0;
    s_wdata_bo = '0;
    m_ack_o    = '0;
    if (!rst_i && cand_vld) begin
      s_req_o    = !blocked;
      s_we_o     = m_we_i[cand];
      s_addr_bo  = m_addr_bi[32*cand +: 32];
      s_be_o     = m_be_i[4*cand +: 4];
      s_wdata_bo = m_wdata_bi[32*cand +: 32];
      if (!blocked && s_ack_i) m_ack_o[cand] = 1'b1;
    end
  end

  assign accept    = s_req_o && s_ack_i;
  assign fifo_push = accept && !s_we_o;
  assign fifo_pop  = !rst_i && s_resp_i && !fifo_empty;

  ariele_rr_id_fifo #(
    .DEPTH (MAX_OUTST),
    .DW    (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_tvalid (fifo_push),
    .wr_tdata  (cand),
    .rd_tready (fifo_pop),
    .rd_tdata  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    m_resp_o = '0;
    if (fifo_pop) m_resp_o[fifo_head] = 1'b1;
  end

  assign m_rdata_bo = rst_i ? '0 : {NUM_M{s_rdata_bi}};
  assign outst_o    = rst_i ? '0 : fifo_count;
  assign err_o      = !rst_i && err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
      err_q   <= 1'b0;
    end else begin
      if (withdrew) begin
        lock  <= 1'b0;
        err_q <= 1'b1;
      end else if (s_req_o && !s_ack_i) begin
        lock    <= 1'b1;
        lock_id <= cand;
      end else if (accept) begin
        lock   <= 1'b0;
        rr_ptr <= (cand == ID_W'(NUM_M - 1)) ? '0 : cand + ID_W'(1);
      end
      // A response with nothing outstanding is dropped and flagged.
      if (s_resp_i && fifo_empty) err_q <= 1'b1;
    end
  end
endmodule
